// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths and FSM encoding for the cache request arbiter
package cache_pkg;

    localparam int ADDR_W          = 15;
    localparam int DATA_W          = 32;
    localparam int MISS_CYCLES_DEF = 2;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2
    } state_t;

endpackage

// File: rtl/cache_req_arbiter_rr_arb2.sv
// rtl/cache_req_arbiter_rr_arb2.sv - two-way round-robin grant, purely combinational
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

    logic w_pick;

    // Favour whichever requester did not win last; fall back to the other one.
    always_comb begin
        w_pick = 1'b0;
        if (last_gnt) begin
            w_pick = req0 ? 1'b0 : 1'b1;
        end else begin
            w_pick = req1 ? 1'b1 : 1'b0;
        end
    end

    assign gnt_valid = req0 | req1;
    assign gnt_id    = w_pick;

endmodule

// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - shares the cache read port between fetch and data requesters
// One access in flight; a miss waits MISS_CYCLES for the refill, then retries once.
module cache_req_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W      = cache_pkg::ADDR_W,
    parameter int DATA_W      = cache_pkg::DATA_W,
    parameter int MISS_CYCLES = cache_pkg::MISS_CYCLES_DEF,
    parameter int CNT_W       = cache_pkg::CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic [DATA_W-1:0] cache_data,
    input  logic              cache_hit,
    output logic [DATA_W-1:0] rdata,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  acc_cnt
);

    localparam int WCNT_W = (MISS_CYCLES > 1) ? $clog2(MISS_CYCLES) : 1;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_cache_addr;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_winner;
    logic               r_last_gnt;
    logic               r_retry;
    logic [WCNT_W-1:0]  r_wcnt;
    logic               r_done0;
    logic               r_done1;
    logic               r_err;
    logic               r_busy;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_acc_cnt;

    logic               w_gnt_valid;
    logic               w_gnt_id;

    rr_arb2 u_rr_arb2 (
        .req0      (req0),
        .req1      (req1),
        .last_gnt  (r_last_gnt),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cache_addr <= '0;
            r_rdata      <= '0;
            r_winner     <= 1'b0;
            r_last_gnt   <= 1'b1;
            r_retry      <= 1'b0;
            r_wcnt       <= '0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_hit_cnt    <= '0;
            r_acc_cnt    <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_cache_addr <= w_gnt_id ? addr1 : addr0;
                        r_winner     <= w_gnt_id;
                        r_last_gnt   <= w_gnt_id;
                        r_retry      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        r_rdata <= cache_data;
                        r_done0 <= ~r_winner;
                        r_done1 <= r_winner;
                        if (r_acc_cnt != {CNT_W{1'b1}}) r_acc_cnt <= r_acc_cnt + 1'b1;
                        // Only hits on the first lookup count; a post-refill hit is a miss.
                        if (!r_retry && r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (!r_retry) begin
                        r_wcnt  <= WCNT_W'(MISS_CYCLES - 1);
                        r_state <= REFILL;
                    end else begin
                        r_rdata <= '0;
                        r_done0 <= ~r_winner;
                        r_done1 <= r_winner;
                        r_err   <= 1'b1;
                        if (r_acc_cnt != {CNT_W{1'b1}}) r_acc_cnt <= r_acc_cnt + 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                REFILL: begin
                    if (r_wcnt == '0) begin
                        r_retry <= 1'b1;
                        r_state <= LOOKUP;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cache_addr = r_cache_addr;
    assign rdata      = r_rdata;
    assign done0      = r_done0;
    assign done1      = r_done1;
    assign err        = r_err;
    assign busy       = r_busy;
    assign hit_cnt    = r_hit_cnt;
    assign acc_cnt    = r_acc_cnt;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb/tb_cache_req_arbiter.sv - scoreboard bench with a transaction-level reference model
module tb_cache_req_arbiter;

    localparam int AW   = 15;
    localparam int DW   = 32;
    localparam int MC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_data;
    logic          cache_hit;
    logic [DW-1:0] rdata;
    logic          done0, done1, err, busy;
    logic [CW-1:0] hit_cnt, acc_cnt;

    cache_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MISS_CYCLES(MC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .addr0      (addr0),
        .req1       (req1),
        .addr1      (addr1),
        .cache_addr (cache_addr),
        .cache_data (cache_data),
        .cache_hit  (cache_hit),
        .rdata      (rdata),
        .done0      (done0),
        .done1      (done1),
        .err        (err),
        .busy       (busy),
        .hit_cnt    (hit_cnt),
        .acc_cnt    (acc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mm(input int a);
        return 32'(a) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Cache model: a missing block is installed after its address has been presented for two edges.
    bit cres [8192];
    bit pois [8192];
    int cm_blk = -1;
    int cm_cnt = 0;

    always @(posedge clk) begin
        int blk;
        blk = int'(cache_addr) >> 2;
        if (blk != cm_blk) begin
            cm_blk = blk;
            cm_cnt = 0;
        end
        if (!cres[blk] && !pois[blk]) begin
            cm_cnt++;
            if (cm_cnt >= 2) cres[blk] = 1'b1;
        end
    end

    always @(negedge clk) begin
        cache_hit  = cres[int'(cache_addr) >> 2];
        cache_data = cache_hit ? mm(int'(cache_addr)) : 32'hDEADBEEF;
    end

    // Reference model: whole transactions, with completion cycle computed from the latency rules.
    typedef struct {
        int          id;
        logic [31:0] data;
        bit          err;
        int          cyc;
        int          hit;
        int          acc;
    } exp_t;

    exp_t q[$];
    bit   rres [8192];
    int   cyc     = 0;
    int   free_at = 0;
    int   m_last  = 1;
    int   m_hit   = 0;
    int   m_acc   = 0;

    always @(posedge clk) begin
        exp_t e;
        int   w, a, blk;
        if (rst) begin
            q.delete();
            free_at = cyc + 1;
            m_last  = 1;
            m_hit   = 0;
            m_acc   = 0;
        end else if (cyc >= free_at && (req0 || req1)) begin
            if (m_last == 0) w = req1 ? 1 : 0;
            else             w = req0 ? 0 : 1;
            a   = (w == 1) ? int'(addr1) : int'(addr0);
            blk = a >> 2;
            e.id = w;
            e.err = 1'b0;
            e.data = mm(a);
            if (m_acc < CMAX) m_acc++;
            if (rres[blk]) begin
                e.cyc = cyc + 2;
                if (m_hit < CMAX) m_hit++;
            end else begin
                e.cyc = cyc + 3 + MC;
                if (pois[blk]) begin
                    e.err  = 1'b1;
                    e.data = 32'h0;
                end else begin
                    rres[blk] = 1'b1;
                end
            end
            e.hit = m_hit;
            e.acc = m_acc;
            q.push_back(e);
            free_at = e.cyc;
            m_last  = w;
        end
        cyc++;
    end

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done0 || done1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", {done1, done0}, 0);
            end else begin
                e = q.pop_front();
                chk("done_both", done0 & done1, 0);
                chk("done_id", done1 ? 1 : 0, e.id);
                chk("done_cycle", cyc, e.cyc);
                chk("rdata", rdata, e.data);
                chk("err", err, e.err);
                chk("hit_cnt", hit_cnt, e.hit);
                chk("acc_cnt", acc_cnt, e.acc);
            end
        end else begin
            if (err) chk("err_without_done", err, 0);
            if (q.size() > 0 && q[0].cyc < cyc) begin
                chk("done_missing", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic do_req(input int id, input int a);
        bit got;
        got = 1'b0;
        if (id == 0) begin req0 = 1'b1; addr0 = AW'(a); end
        else         begin req1 = 1'b1; addr1 = AW'(a); end
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if ((id == 0 && done0) || (id == 1 && done1)) got = 1'b1;
        end
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
        if (!got) chk("req_timeout", 0, 1);
    endtask

    task automatic rand_stream(input int id, input int n);
        int a;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) a = 2048 + int'($urandom_range(0, 3));
            else                           a = 1024 + int'($urandom_range(0, 31));
            do_req(id, a);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0;  addr1 = '0;
        pois[2048 >> 2] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cache_addr", cache_addr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_acc_cnt", acc_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        do_req(0, 1024);
        do_req(0, 1025);

        for (int r = 0; r < 4; r++) begin
            fork
                do_req(0, 1024);
                do_req(1, 1026);
            join
        end

        do_req(1, 2048);

        req0 = 1'b1; addr0 = AW'(3000);
        repeat (2) @(negedge clk);
        chk("refill_busy", busy, 1);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done0", done0, 0);
        chk("abort_hit_cnt", hit_cnt, 0);
        chk("abort_acc_cnt", acc_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        do_req(0, 1027);

        fork
            rand_stream(0, 25);
            rand_stream(1, 25);
        join

        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("acc_saturated", acc_cnt, CMAX);
        chk("hit_final", hit_cnt, m_hit);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
